// File: rtl/aftab_divider_pkg.sv
// Shared constants for the AFTAB radix-2 restoring divider.
package aftab_divider_pkg;

    // Controller state encoding.
    localparam logic [1:0] DIV_IDLE = 2'd0;
    localparam logic [1:0] DIV_RUN  = 2'd1;
    localparam logic [1:0] DIV_DONE = 2'd2;

    // Default operand width used by the AAU.
    localparam int DIV_SIZE = 33;

    // Width of the step counter; it must hold the value DIV_SIZE.
    localparam int DIV_CNT_W = $clog2(DIV_SIZE + 1);

endpackage

// File: rtl/aftab_divider_controller.sv
// Control path of the divider: state register, step counter and the
// load / shift / busy / done strobes for the datapath in the top module.
module aftab_divider_controller
    import aftab_divider_pkg::*;
#(
    parameter int size = DIV_SIZE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       divisor_zero,
    output logic       load,
    output logic       load_dbz,
    output logic       shift,
    output logic       busy,
    output logic       done,
    output logic [1:0] state
);

    localparam int CW = $clog2(size + 1);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] count_q, count_d;

    // State and step counter registers; reset aborts any division in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= DIV_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Next-state logic: start is only honoured in IDLE, nothing is queued.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            DIV_IDLE: begin
                if (start) begin
                    if (divisor_zero) begin
                        state_d = DIV_DONE;
                    end else begin
                        state_d = DIV_RUN;
                        count_d = CW'(size);
                    end
                end
            end
            DIV_RUN: begin
                count_d = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    state_d = DIV_DONE;
                end
            end
            DIV_DONE: state_d = DIV_IDLE;
            default:  state_d = DIV_IDLE;
        endcase
    end

    // Output decode: datapath strobes plus registered-state status flags.
    always_comb begin
        load     = (state_q == DIV_IDLE) && start && !divisor_zero;
        load_dbz = (state_q == DIV_IDLE) && start && divisor_zero;
        shift    = (state_q == DIV_RUN);
        busy     = (state_q != DIV_IDLE);
        done     = (state_q == DIV_DONE);
        state    = state_q;
    end

endmodule

// File: rtl/aftab_divider.sv
// AFTAB sequential unsigned restoring divider, one quotient bit per clock.
// Start/done handshake: start is sampled only while idle; the edge that sees
// start=1 in IDLE accepts the operands. done pulses for one cycle when
// quotient/remainder/dbz are valid; they hold until the next accepted start.
module aftab_divider
    import aftab_divider_pkg::*;
#(
    parameter int size = DIV_SIZE
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [size-1:0] dividend,
    input  logic [size-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic            dbz,
    output logic [size-1:0] quotient,
    output logic [size-1:0] remainder,
    output logic [1:0]      dbg_state
);

    logic load, load_dbz, shift;

    // Partial remainder is size+1 bits so the trial subtraction cannot wrap.
    logic [size:0]   r_q, r_d;
    logic [size-1:0] q_q, q_d;
    logic [size-1:0] d_q, d_d;
    logic            dbz_q, dbz_d;

    // The shifted value carries the old top bit of R so the sign of the
    // trial difference is taken one bit above R; R's top bit is always 0.
    logic [size+1:0] r_shift;
    logic [size+1:0] trial;

    aftab_divider_controller #(
        .size(size)
    ) u_ctrl (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .divisor_zero(divisor == '0),
        .load        (load),
        .load_dbz    (load_dbz),
        .shift       (shift),
        .busy        (busy),
        .done        (done),
        .state       (dbg_state)
    );

    // Datapath registers: remainder, quotient/dividend, divisor, dbz flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q   <= '0;
            q_q   <= '0;
            d_q   <= '0;
            dbz_q <= 1'b0;
        end else begin
            r_q   <= r_d;
            q_q   <= q_d;
            d_q   <= d_d;
            dbz_q <= dbz_d;
        end
    end

    // Load operands, or perform one shift/trial-subtract/restore step.
    always_comb begin
        r_shift = {r_q, q_q[size-1]};
        trial   = r_shift - {2'b00, d_q};
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        dbz_d   = dbz_q;
        if (load) begin
            r_d   = '0;
            q_d   = dividend;
            d_d   = divisor;
            dbz_d = 1'b0;
        end else if (load_dbz) begin
            // Divide by zero follows the RISC-V result convention.
            r_d   = {1'b0, dividend};
            q_d   = '1;
            dbz_d = 1'b1;
        end else if (shift) begin
            if (!trial[size+1]) begin
                r_d = trial[size:0];
                q_d = {q_q[size-2:0], 1'b1};
            end else begin
                r_d = r_shift[size:0];
                q_d = {q_q[size-2:0], 1'b0};
            end
        end
    end

    // Results come straight from the registers; no input-to-output path.
    always_comb begin
        dbz       = dbz_q;
        quotient  = q_q;
        remainder = r_q[size-1:0];
    end

endmodule

// File: doc/aftab_divider.md
# aftab_divider

Sequential unsigned radix-2 restoring divider for the AFTAB arithmetic unit (AAU). It is the inverse-operation companion to the Booth multiplier and uses the same start/done handshake, so the AAU controller can drive either unit the same way. The AAU performs sign handling and operand sign-extension before and after this block. The divider computes one quotient bit per clock.

## Interface
Parameters:
- size, 33: operand width. The AAU passes 33-bit zero- or sign-magnitude-adjusted operands.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  reset, asynchronous, active-low
- start  input  1  request a division; sampled only in IDLE
- dividend  input  size  numerator; captured on the accepted start
- divisor  input  size  denominator; captured on the accepted start
- busy  output  1  high from the cycle after an accepted start until done deasserts
- done  output  1  one-cycle pulse; quotient and remainder are valid
- dbz  output  1  divide-by-zero flag; valid with done and held until the next accepted start
- quotient  output  size  result quotient; held until the next accepted start
- remainder  output  size  result remainder; held until the next accepted start

## Operation
- State machine IDLE -> RUN -> DONE -> IDLE, with a shortcut IDLE -> DONE on divide-by-zero.
- IDLE, start=1, divisor≠0:
  - R(size+1 bits) := 0, Q := dividend, D := divisor, count := size, dbz := 0.
  - Next state RUN.
- IDLE, start=1, divisor=0:
  - quotient := all ones, remainder := dividend, dbz := 1 (RISC-V convention).
  - Next state DONE.
- RUN, each cycle:
  - {R,Q} shifted left 1; trial T = R_shifted − {1'b0,D}.
  - If T ≥ 0 (MSB of T is 0): R := T and Q[0] := 1; otherwise R keeps the shifted value and Q[0] := 0.
  - count decrements. On the step where count goes 1 -> 0, next state is DONE.
- DONE: done=1 for exactly one cycle; quotient = Q, remainder = R[size-1:0]. Next state IDLE.
- start while in RUN or DONE is ignored. Operands are not re-captured and no request is queued.
- Dividend < divisor is handled by the same loop: quotient 0, remainder = dividend, full latency, no special case.
- The partial remainder is held at size+1 bits so the trial subtraction never overflows. The remainder output is truncated to size bits; the truncated bit is always 0.

## Timing
- Reset (rst=0, asynchronous): state IDLE, busy=0, done=0, dbz=0, quotient=0, remainder=0, count=0.
- A reset mid-operation aborts immediately; there is no partial result.
- Latency is measured from start high in cycle 0, with the edge at the end of cycle 0 accepting it:
  - Normal: RUN occupies cycles 1..size. done=1 in cycle size+1 (cycle 34 for size=33). Next start is accepted in cycle size+2 at the earliest.
  - Divide by zero: done=1 in cycle 1. Next start is accepted in cycle 2 at the earliest.
- busy=1 in cycles 1..size+1 (normal) or in cycle 1 (divide by zero). busy=0 in IDLE.
- Outputs are registered, with no combinational path from inputs to outputs.
- quotient and remainder are stable from the done cycle until the edge that accepts the next start.
- The dividend and divisor inputs may change freely after the accepting edge.

## Structure
- Shared package aftab_divider_pkg holds:
  - State encoding constants DIV_IDLE, DIV_RUN, DIV_DONE (2-bit).
  - Default width constant DIV_SIZE = 33.
  - Counter width as $clog2(DIV_SIZE+1).
- One sub-module, aftab_divider_controller: state register, count, and generation of the load, shift, busy and done controls.
- The datapath registers (R, Q, D, trial subtractor) stay in the top module, matching the multiplier's control/datapath partitioning.

## Test plan
- size=33, 100/7 -> done exactly in cycle 34, quotient=14, remainder=2, dbz=0, busy high in cycles 1..34.
- 0x1_FFFF_FFFF / 1 -> quotient=0x1_FFFF_FFFF, remainder=0; then 5/9 -> quotient=0, remainder=5, full 34-cycle latency.
- 42/0 -> done in cycle 1, dbz=1, quotient=0x1_FFFF_FFFF, remainder=42. An immediately following 42/6 gives quotient=7, remainder=0, dbz=0.
- start pulsed again in cycles 5 and 34 during a 1000/10 division -> ignored, one done pulse only, quotient=100, remainder=0.
- rst low in cycle 10 of a division -> all outputs 0 at once, state IDLE. A new start after release gives a correct, independent result.
- Randomized 10k operand pairs against the reference model Q=a/b, R=a%b, with done exactly size+1 cycles after start.
